// File: rtl/handshakes_pkg.sv
// rtl/handshakes_pkg.sv - shared state encoding for the handshakes_delay_ready slice
package handshakes_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/hsk_sat_counter.sv
// rtl/hsk_sat_counter.sv - saturating up-counter, cleared only by rst
module hsk_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/handshakes_delay_ready.sv
// rtl/handshakes_delay_ready.sv - two-entry skid buffer with registered valid, ready and data
// Optional stall counter port enabled by HANDSHAKES_DELAY_READY_STAT_EN.
module handshakes_delay_ready
   import handshakes_pkg::*;
#(
   parameter int WORD_WIDTH = 8
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
  ,parameter int CNT_WIDTH  = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  up_valid,
   input  logic [WORD_WIDTH-1:0] up_data,
   output logic                  up_ready,
   output logic                  down_valid,
   output logic [WORD_WIDTH-1:0] down_data,
   input  logic                  down_ready
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
  ,output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

   state_e                state_q, state_d;
   logic [WORD_WIDTH-1:0] out_q, out_d;
   logic [WORD_WIDTH-1:0] skid_q, skid_d;
   logic                  down_valid_q;
   logic                  up_ready_q;
   logic                  up_fire;
   logic                  down_fire;

   assign up_fire   = up_valid & up_ready_q;
   assign down_fire = down_valid_q & down_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (up_fire) begin
               out_d   = up_data;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (up_fire && down_fire) begin
               out_d = up_data;
            end else if (up_fire) begin
               skid_d  = up_data;
               state_d = FULL;
            end else if (down_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // up_ready is low here, so only the drain side can move
            if (down_fire) begin
               out_d   = skid_q;
               state_d = BUSY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         out_q        <= '0;
         skid_q       <= '0;
         down_valid_q <= 1'b0;
         up_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         skid_q       <= skid_d;
         down_valid_q <= (state_d != EMPTY);
         up_ready_q   <= (state_d != FULL);
      end
   end

   assign up_ready   = up_ready_q;
   assign down_valid = down_valid_q;
   assign down_data  = out_q;

`ifdef HANDSHAKES_DELAY_READY_STAT_EN
   hsk_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (down_valid_q & ~down_ready),
      .cnt (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_handshakes_delay_ready.sv
// tb/tb_handshakes_delay_ready.sv - self-checking bench for handshakes_delay_ready
// Stall counter checks compile in with HANDSHAKES_DELAY_READY_STAT_EN.
module tb_handshakes_delay_ready;

   localparam int WORD_WIDTH = 8;
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
   localparam int CNT_WIDTH = 4;
   localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  up_valid;
   logic [WORD_WIDTH-1:0] up_data;
   logic                  up_ready;
   logic                  down_valid;
   logic [WORD_WIDTH-1:0] down_data;
   logic                  down_ready;
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
   logic [CNT_WIDTH-1:0]  stall_cnt;
`endif

   always #10 clk = ~clk;

   handshakes_delay_ready #(
      .WORD_WIDTH (WORD_WIDTH)
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
     ,.CNT_WIDTH  (CNT_WIDTH)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_ready   (up_ready),
      .down_valid (down_valid),
      .down_data  (down_data),
      .down_ready (down_ready)
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
     ,.stall_cnt  (stall_cnt)
`endif
   );

   typedef struct {
      logic                  r;
      logic                  uv;
      logic [WORD_WIDTH-1:0] ud;
      logic                  dr;
      logic                  dv;
      logic                  ur;
      logic [WORD_WIDTH-1:0] dd;
      logic                  chk_dd;
   } vec_t;

   vec_t vecs[11];

   int checks = 0;
   int errors = 0;

   // reference model: words held in acceptance order, plus the expected ready flag
   logic [WORD_WIDTH-1:0] held[$];
   logic                  ready_exp = 1'b0;
   int                    stall_exp = 0;
   logic                  was_stalled = 1'b0;
   logic [WORD_WIDTH-1:0] stalled_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic uv, input logic [WORD_WIDTH-1:0] ud, input logic dr);
      bit uf, df, stall;
      rst        = r;
      up_valid   = uv;
      up_data    = ud;
      down_ready = dr;
      uf    = uv && ready_exp;
      df    = (held.size() > 0) && dr;
      stall = (held.size() > 0) && !dr;
      was_stalled  = !r && down_valid && !dr;
      stalled_data = down_data;
      @(posedge clk);
      #1;
      if (r) begin
         held.delete();
         ready_exp = 1'b0;
         stall_exp = 0;
      end else begin
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
         if (stall && stall_exp < CNT_MAX) stall_exp++;
`else
         if (stall) stall_exp++;
`endif
         if (df) void'(held.pop_front());
         if (uf) held.push_back(ud);
         ready_exp = (held.size() < 2);
      end
   endtask

   task automatic check_model(input string name);
      chk({name, "_dv"}, down_valid, held.size() > 0);
      chk({name, "_ur"}, up_ready, ready_exp);
      if (held.size() > 0) chk({name, "_dd"}, down_data, held[0]);
      if (was_stalled) chk({name, "_hold"}, down_data, stalled_data);
`ifdef HANDSHAKES_DELAY_READY_STAT_EN
      chk({name, "_stall"}, stall_cnt, stall_exp);
`endif
   endtask

   initial begin
      #(200000 * 20);
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      // reset, then fill to FULL with 11/22 while 33 waits upstream, then drain
      vecs[0]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[1]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};

      rst        = 1'b1;
      up_valid   = 1'b0;
      up_data    = '0;
      down_ready = 1'b0;

      for (int i = 0; i < 11; i++) begin
         step(vecs[i].r, vecs[i].uv, vecs[i].ud, vecs[i].dr);
         chk($sformatf("vec%0d_dv", i), down_valid, vecs[i].dv);
         chk($sformatf("vec%0d_ur", i), up_ready, vecs[i].ur);
         if (vecs[i].chk_dd) chk($sformatf("vec%0d_dd", i), down_data, vecs[i].dd);
      end

      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b1);
         check_model($sformatf("stream%0d", i));
         chk($sformatf("stream%0d_data", i), down_data, 32'(i));
         chk($sformatf("stream%0d_ready", i), up_ready, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check_model("stream_tail");
      end

      for (int c = 0; c < 200; c++) begin
         step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), c[0]);
         check_model("alt");
      end
      for (int c = 0; c < 300; c++) begin
         step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
         check_model("rand");
      end

      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check_model("pre_full");
      end
      step(1'b0, 1'b1, 8'h44, 1'b0);
      check_model("fill44");
      step(1'b0, 1'b1, 8'h55, 1'b0);
      check_model("fill55");
      chk("full_ur", up_ready, 1'b0);
      chk("full_dd", down_data, 8'h44);
      step(1'b1, 1'b1, 8'h66, 1'b0);
      chk("midrst_dv", down_valid, 1'b0);
      chk("midrst_ur", up_ready, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check_model("post_rst");
         chk("post_rst_no_word", down_valid, 1'b0);
      end

`ifdef HANDSHAKES_DELAY_READY_STAT_EN
      step(1'b0, 1'b1, 8'h77, 1'b0);
      check_model("stat_load");
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b0);
         check_model("stat_hold");
      end
      chk("stat_saturated", stall_cnt, 4'hF);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("stat_cleared", stall_cnt, 4'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
